ahblite_interconnect_n: RTL and testbench

- Parametrised single-master AHB-Lite interconnect: N slaves, configurable address/data width, per-slave base/mask address map.
- Registered data-phase response mux and a built-in default slave that returns the two-cycle AHB ERROR for unmapped accesses.
- Fault capture (last faulting address, saturating error counter) for software diagnosis.
- Sits between the core bus master and the peripheral set; replaces fixed 4-port interconnect instances.

---
 rtl/ahb_pkg.sv | 21 ++
 rtl/ahblite_default_slave.sv | 75 +++++++
 rtl/ahblite_interconnect_n.sv | 118 +++++++++++
 tb/tb_ahblite_interconnect_n.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// interconnect slice.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OK   = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave for unmapped addresses: two-cycle AHB ERROR response plus
// capture of the faulting address and a saturating error counter.
//
// state   | meaning
// DS_OK   | idle / zero-wait OKAY for IDLE and BUSY to unmapped space
// DS_ERR1 | first error cycle, HREADY low, HRESP ERROR
// DS_ERR2 | second error cycle, HREADY high, HRESP ERROR
module ahblite_default_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hready,
  input  logic              trans_active,
  input  logic              nomatch,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              err_clr,
  output logic              ds_ready,
  output logic              ds_resp,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fault_addr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ds_state_e state_q, state_d;
  logic      err_entry;

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= DS_OK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ds_ready = 1'b1;
    ds_resp  = HRESP_OKAY;
    case (state_q)
      DS_OK: begin
        if (hready && trans_active && nomatch) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ds_ready = 1'b0;
        ds_resp  = HRESP_ERROR;
        state_d  = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp = HRESP_ERROR;
        state_d = (trans_active && nomatch) ? DS_ERR1 : DS_OK;
      end
      default: state_d = DS_OK;
    endcase
  end

  // DS_ERR1 is only ever entered from DS_OK or DS_ERR2, so this marks a new error
  assign err_entry = (state_d == DS_ERR1);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      err_count  <= '0;
      fault_addr <= '0;
    end else begin
      if (err_entry) fault_addr <= haddr;
      if (err_clr)
        err_count <= err_entry ? CNT_ONE : '0;
      else if (err_entry && (err_count != CNT_MAX))
        err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: rtl/ahblite_interconnect_n.sv
// Single-master AHB-Lite interconnect: base/mask address decode, registered
// data-phase response mux and a built-in default slave for unmapped space.
module ahblite_interconnect_n
  import ahb_pkg::*;
#(
  parameter int                           NUM_SLAVES = 4,
  parameter int                           ADDR_W     = 32,
  parameter int                           DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = {NUM_SLAVES{{ADDR_W{1'b0}}}},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = {NUM_SLAVES{{4'hF, {(ADDR_W-4){1'b0}}}}},
  parameter int                           CNT_W      = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [3:0]                   HPROT,
  input  logic                         HMASTLOCK,
  input  logic [DATA_W-1:0]            HWDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [DATA_W-1:0]            HRDATA,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  output logic [ADDR_W-1:0]            HADDR_S,
  output logic [1:0]                   HTRANS_S,
  output logic                         HWRITE_S,
  output logic [2:0]                   HSIZE_S,
  output logic [2:0]                   HBURST_S,
  output logic [3:0]                   HPROT_S,
  output logic                         HMASTLOCK_S,
  output logic [DATA_W-1:0]            HWDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic                         err_clr,
  output logic [CNT_W-1:0]             err_count,
  output logic [ADDR_W-1:0]            fault_addr
);

  logic [NUM_SLAVES-1:0] hsel;
  logic                  nomatch;
  logic [NUM_SLAVES:0]   dsel_q;
  logic                  trans_active;
  logic                  ds_ready;
  logic                  ds_resp;
  logic                  hready_mux;
  logic                  hresp_mux;
  logic [DATA_W-1:0]     hrdata_mux;

  // Lowest index wins on overlapping windows
  always_comb begin
    hsel    = '0;
    nomatch = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (nomatch &&
          ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hsel[i] = 1'b1;
        nomatch = 1'b0;
      end
    end
  end

  assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

  assign HSEL_S      = hsel;
  assign HADDR_S     = HADDR;
  assign HTRANS_S    = HTRANS;
  assign HWRITE_S    = HWRITE;
  assign HSIZE_S     = HSIZE;
  assign HBURST_S    = HBURST;
  assign HPROT_S     = HPROT;
  assign HMASTLOCK_S = HMASTLOCK;
  assign HWDATA_S    = HWDATA;

  // Top bit of dsel is the default slave
  always_ff @(posedge HCLK) begin
    if (HRESET)      dsel_q <= {1'b1, {NUM_SLAVES{1'b0}}};
    else if (HREADY) dsel_q <= {nomatch, hsel};
  end

  always_comb begin
    hready_mux = ds_ready;
    hresp_mux  = ds_resp;
    hrdata_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        hready_mux = HREADYOUT_S[i];
        hresp_mux  = HRESP_S[i];
        hrdata_mux = HRDATA_S[i*DATA_W +: DATA_W];
      end
    end
  end

  assign HREADY = hready_mux;
  assign HRESP  = hresp_mux;
  assign HRDATA = hrdata_mux;

  ahblite_default_slave #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_default_slave (
    .hclk         (HCLK),
    .hreset       (HRESET),
    .hready       (HREADY),
    .trans_active (trans_active),
    .nomatch      (nomatch),
    .haddr        (HADDR),
    .err_clr      (err_clr),
    .ds_ready     (ds_ready),
    .ds_resp      (ds_resp),
    .err_count    (err_count),
    .fault_addr   (fault_addr)
  );

endmodule

// File: tb/tb_ahblite_interconnect_n.sv
// Bench for ahblite_interconnect_n: directed scenarios plus a randomized run
// against a transfer-level model of the expected bus response.
module tb_ahblite_interconnect_n;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [N*AW-1:0] BASES = {32'h5000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [N*AW-1:0] MASKS = {N{32'hF000_0000}};

  localparam int K_OKAY = -1;
  localparam int K_ERR1 = -2;
  localparam int K_ERR2 = -3;

  logic          HCLK, HRESET;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE, HMASTLOCK, err_clr;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [DW-1:0] HWDATA;
  logic [N-1:0]  HREADYOUT_S, HRESP_S;
  logic [N*DW-1:0] HRDATA_S;

  logic          HREADY, HRESP, HWRITE_S, HMASTLOCK_S;
  logic [DW-1:0] HRDATA, HWDATA_S;
  logic [N-1:0]  HSEL_S;
  logic [AW-1:0] HADDR_S, fault_addr;
  logic [1:0]    HTRANS_S;
  logic [2:0]    HSIZE_S, HBURST_S;
  logic [3:0]    HPROT_S;
  logic [7:0]    err_count;

  logic          sat_hready, sat_hresp, sat_hwrite, sat_hmastlock;
  logic [DW-1:0] sat_hrdata, sat_hwdata;
  logic [N-1:0]  sat_hsel;
  logic [AW-1:0] sat_haddr, sat_fault;
  logic [1:0]    sat_htrans;
  logic [2:0]    sat_hsize, sat_hburst;
  logic [3:0]    sat_hprot;
  logic [1:0]    sat_count;

  int n_chk = 0;
  int n_pass = 0;

  int          m_kind = K_OKAY;
  int          m_cnt8 = 0;
  int          m_cnt2 = 0;
  logic [31:0] m_fault = '0;

  ahblite_interconnect_n #(
    .NUM_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE(BASES), .SLV_MASK(MASKS), .CNT_W(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .HSEL_S(HSEL_S),
    .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HWRITE_S(HWRITE_S), .HSIZE_S(HSIZE_S),
    .HBURST_S(HBURST_S), .HPROT_S(HPROT_S), .HMASTLOCK_S(HMASTLOCK_S), .HWDATA_S(HWDATA_S),
    .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
    .err_clr(err_clr), .err_count(err_count), .fault_addr(fault_addr)
  );

  ahblite_interconnect_n #(
    .NUM_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE(BASES), .SLV_MASK(MASKS), .CNT_W(2)
  ) dut_sat (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(sat_hready), .HRESP(sat_hresp), .HRDATA(sat_hrdata), .HSEL_S(sat_hsel),
    .HADDR_S(sat_haddr), .HTRANS_S(sat_htrans), .HWRITE_S(sat_hwrite), .HSIZE_S(sat_hsize),
    .HBURST_S(sat_hburst), .HPROT_S(sat_hprot), .HMASTLOCK_S(sat_hmastlock), .HWDATA_S(sat_hwdata),
    .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
    .err_clr(err_clr), .err_count(sat_count), .fault_addr(sat_fault)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Address map of the test setup, by top nibble
  function automatic int region(logic [31:0] a);
    logic [3:0] nib;
    nib = a[31:28];
    case (nib)
      4'h0: return 0;
      4'h2: return 1;
      4'h4: return 2;
      4'h5: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic exp_ready();
    if (m_kind >= 0) return HREADYOUT_S[m_kind];
    return (m_kind != K_ERR1);
  endfunction

  function automatic logic exp_resp();
    if (m_kind >= 0) return HRESP_S[m_kind];
    return (m_kind == K_ERR1) || (m_kind == K_ERR2);
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (m_kind >= 0) return HRDATA_S[m_kind*DW +: DW];
    return 32'h0;
  endfunction

  function automatic logic [3:0] exp_hsel(logic [31:0] a);
    int r;
    logic [3:0] v;
    r = region(a);
    v = '0;
    if (r >= 0) v[r] = 1'b1;
    return v;
  endfunction

  // One clock: advance the model from the inputs the DUT samples on this edge
  task automatic tick();
    int nk, n8, n2, r;
    logic [31:0] nf;
    logic new_err;
    nk = m_kind; n8 = m_cnt8; n2 = m_cnt2; nf = m_fault; new_err = 1'b0;
    if (HRESET) begin
      nk = K_OKAY; n8 = 0; n2 = 0; nf = '0;
    end else begin
      if (m_kind == K_ERR1) nk = K_ERR2;
      else if (exp_ready()) begin
        r = region(HADDR);
        if (r >= 0) nk = r;
        else if (HTRANS == 2'b10 || HTRANS == 2'b11) begin nk = K_ERR1; new_err = 1'b1; end
        else nk = K_OKAY;
      end
      if (new_err) nf = HADDR;
      if (err_clr) begin
        n8 = new_err ? 1 : 0;
        n2 = new_err ? 1 : 0;
      end else if (new_err) begin
        n8 = (n8 < 255) ? n8 + 1 : 255;
        n2 = (n2 < 3) ? n2 + 1 : 3;
      end
    end
    @(posedge HCLK);
    m_kind = nk; m_cnt8 = n8; m_cnt2 = n2; m_fault = nf;
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HADDR = 32'h4000_0000; HTRANS = 2'b00; err_clr = 1'b0;
    HREADYOUT_S = '1; HRESP_S = '0;
    HRDATA_S = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    tick(); tick();
    HRESET = 1'b0; #1;
    n_chk++; if (HREADY !== 1'b1) $display("FAIL reset_hready: got %b want 1", HREADY); else n_pass++;
    n_chk++; if (HRESP !== 1'b0) $display("FAIL reset_hresp: got %b want 0", HRESP); else n_pass++;
    n_chk++; if (HRDATA !== 32'h0) $display("FAIL reset_hrdata: got %h want 0", HRDATA); else n_pass++;
    n_chk++; if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d want 0", err_count); else n_pass++;
    n_chk++; if (fault_addr !== 32'h0) $display("FAIL reset_fault_addr: got %h want 0", fault_addr); else n_pass++;
    n_chk++; if (HSEL_S !== 4'b0100) $display("FAIL reset_hsel: got %b want 0100", HSEL_S); else n_pass++;
    HADDR = 32'h5000_0100; #1;
    n_chk++; if (HSEL_S !== 4'b1000) $display("FAIL decode_immediate: got %b want 1000", HSEL_S); else n_pass++;
  endtask

  task automatic test_mapped_read();
    HADDR = 32'h2000_0010; HTRANS = 2'b10; HWRITE = 1'b0; #1;
    n_chk++; if (HSEL_S !== 4'b0010) $display("FAIL read_hsel: got %b want 0010", HSEL_S); else n_pass++;
    tick();
    HTRANS = 2'b00; HADDR = 32'h0000_0000; HREADYOUT_S = 4'b1101; HRDATA_S[63:32] = 32'h0; #1;
    n_chk++; if (HREADY !== 1'b0) $display("FAIL read_wait: got %b want 0", HREADY); else n_pass++;
    tick();
    HREADYOUT_S = 4'b1111; HRDATA_S[63:32] = 32'hDEAD_BEEF; HRESP_S = '0; #1;
    n_chk++; if (HREADY !== 1'b1) $display("FAIL read_done_ready: got %b want 1", HREADY); else n_pass++;
    n_chk++; if (HRDATA !== 32'hDEAD_BEEF) $display("FAIL read_data: got %h want deadbeef", HRDATA); else n_pass++;
    n_chk++; if (HRESP !== 1'b0) $display("FAIL read_resp: got %b want 0", HRESP); else n_pass++;
    tick();
  endtask

  task automatic test_unmapped_write();
    HADDR = 32'h9000_0000; HTRANS = 2'b10; HWRITE = 1'b1; HWDATA = $urandom; #1;
    n_chk++; if (HSEL_S !== 4'b0000) $display("FAIL unmapped_hsel: got %b want 0000", HSEL_S); else n_pass++;
    tick();
    HTRANS = 2'b00; #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b01) $display("FAIL err1_ready_resp: got %b want 01", {HREADY, HRESP}); else n_pass++;
    tick(); #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b11) $display("FAIL err2_ready_resp: got %b want 11", {HREADY, HRESP}); else n_pass++;
    n_chk++; if (fault_addr !== 32'h9000_0000) $display("FAIL unmapped_fault: got %h want 90000000", fault_addr); else n_pass++;
    n_chk++; if (err_count !== 8'd1) $display("FAIL unmapped_count: got %0d want 1", err_count); else n_pass++;
    tick(); #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b10) $display("FAIL idle_unmapped_okay: got %b want 10", {HREADY, HRESP}); else n_pass++;
    tick(); #1;
    n_chk++; if (err_count !== 8'd1) $display("FAIL idle_count_held: got %0d want 1", err_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    HRESET = 1'b1; tick(); HRESET = 1'b0;
    HADDR = 32'h9000_0000; HTRANS = 2'b10;
    tick(); #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b01) $display("FAIL b2b_first_err1: got %b want 01", {HREADY, HRESP}); else n_pass++;
    tick();
    HADDR = 32'hA000_0004; HTRANS = 2'b10; #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b11) $display("FAIL b2b_first_err2: got %b want 11", {HREADY, HRESP}); else n_pass++;
    tick(); #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b01) $display("FAIL b2b_second_err1: got %b want 01", {HREADY, HRESP}); else n_pass++;
    tick();
    HTRANS = 2'b00; #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b11) $display("FAIL b2b_second_err2: got %b want 11", {HREADY, HRESP}); else n_pass++;
    n_chk++; if (fault_addr !== 32'hA000_0004) $display("FAIL b2b_fault: got %h want a0000004", fault_addr); else n_pass++;
    n_chk++; if (err_count !== 8'd2) $display("FAIL b2b_count: got %0d want 2", err_count); else n_pass++;
    tick();
    for (int k = 0; k < 3; k++) begin
      HADDR = 32'hB000_0000 + 32'(k * 4); HTRANS = 2'b10;
      tick(); tick();
      HTRANS = 2'b00;
      tick();
    end
    #1;
    n_chk++; if (err_count !== 8'd5) $display("FAIL five_errors_count: got %0d want 5", err_count); else n_pass++;
    n_chk++; if (sat_count !== 2'd3) $display("FAIL saturate_cnt2: got %0d want 3", sat_count); else n_pass++;
  endtask

  task automatic test_err_clr();
    HADDR = 32'hC000_0000; HTRANS = 2'b10; err_clr = 1'b1;
    tick();
    err_clr = 1'b0; HTRANS = 2'b00; #1;
    n_chk++; if (err_count !== 8'd1) $display("FAIL clr_with_error: got %0d want 1", err_count); else n_pass++;
    n_chk++; if (sat_count !== 2'd1) $display("FAIL clr_with_error_cnt2: got %0d want 1", sat_count); else n_pass++;
    n_chk++; if (fault_addr !== 32'hC000_0000) $display("FAIL clr_fault: got %h want c0000000", fault_addr); else n_pass++;
    tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; #1;
    n_chk++; if (err_count !== 8'd0) $display("FAIL clr_alone: got %0d want 0", err_count); else n_pass++;
  endtask

  task automatic test_reset_in_err();
    HADDR = 32'hD000_0000; HTRANS = 2'b10;
    tick();
    HTRANS = 2'b00; HRESET = 1'b1; #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b01) $display("FAIL pre_reset_err1: got %b want 01", {HREADY, HRESP}); else n_pass++;
    tick();
    HRESET = 1'b0; #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b10) $display("FAIL reset_mid_err: got %b want 10", {HREADY, HRESP}); else n_pass++;
    n_chk++; if (err_count !== 8'd0) $display("FAIL reset_mid_err_count: got %0d want 0", err_count); else n_pass++;
    tick(); #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b10) $display("FAIL after_reset_ok: got %b want 10", {HREADY, HRESP}); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] nib;
    HRESET = 1'b1; tick(); HRESET = 1'b0;
    for (int c = 0; c < 600; c++) begin
      HRESET = ($urandom_range(0, 63) == 0);
      nib = 4'($urandom_range(0, 15));
      HADDR = {nib, 28'($urandom)};
      HTRANS = 2'($urandom_range(0, 3));
      HWRITE = 1'($urandom); HSIZE = 3'($urandom); HBURST = 3'($urandom);
      HPROT = 4'($urandom); HMASTLOCK = 1'($urandom); HWDATA = $urandom;
      for (int s = 0; s < N; s++) begin
        HREADYOUT_S[s] = ($urandom_range(0, 3) != 0);
        HRESP_S[s] = ($urandom_range(0, 7) == 0);
        HRDATA_S[s*DW +: DW] = $urandom;
      end
      err_clr = ($urandom_range(0, 15) == 0);
      #1;
      n_chk++; if (HREADY !== exp_ready()) $display("FAIL rnd_hready c%0d: got %b want %b", c, HREADY, exp_ready()); else n_pass++;
      n_chk++; if (HRESP !== exp_resp()) $display("FAIL rnd_hresp c%0d: got %b want %b", c, HRESP, exp_resp()); else n_pass++;
      n_chk++; if (HRDATA !== exp_rdata()) $display("FAIL rnd_hrdata c%0d: got %h want %h", c, HRDATA, exp_rdata()); else n_pass++;
      n_chk++; if (HSEL_S !== exp_hsel(HADDR)) $display("FAIL rnd_hsel c%0d: got %b want %b", c, HSEL_S, exp_hsel(HADDR)); else n_pass++;
      n_chk++; if (err_count !== 8'(m_cnt8)) $display("FAIL rnd_err_count c%0d: got %0d want %0d", c, err_count, m_cnt8); else n_pass++;
      n_chk++; if (sat_count !== 2'(m_cnt2)) $display("FAIL rnd_sat_count c%0d: got %0d want %0d", c, sat_count, m_cnt2); else n_pass++;
      n_chk++; if (fault_addr !== m_fault) $display("FAIL rnd_fault c%0d: got %h want %h", c, fault_addr, m_fault); else n_pass++;
      n_chk++; if (sat_hready !== exp_ready()) $display("FAIL rnd_sat_hready c%0d: got %b want %b", c, sat_hready, exp_ready()); else n_pass++;
      n_chk++; if ({HADDR_S, HWDATA_S} !== {HADDR, HWDATA}) $display("FAIL rnd_broadcast c%0d: got %h %h want %h %h", c, HADDR_S, HWDATA_S, HADDR, HWDATA); else n_pass++;
      tick();
    end
  endtask

  initial begin
    HRESET = 1'b1; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2;
    HBURST = 3'd0; HPROT = 4'h3; HMASTLOCK = 1'b0; HWDATA = '0; err_clr = 1'b0;
    HREADYOUT_S = '1; HRESP_S = '0; HRDATA_S = '0;
    test_reset();
    test_mapped_read();
    test_unmapped_write();
    test_back_to_back();
    test_err_clr();
    test_reset_in_err();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

endmodule
